// File: rtl/fmul_arbiter.sv
// Two-port round-robin front end for one shared single-precision multiplier.
// Build with FMUL_ARB_STATS_EN defined to add the stat_issued/stat_errors counters.
module fmul_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_sign,
  input  logic [7:0]  mul_exp,
  input  logic [23:0] mul_frac,
  input  logic        mul_error,
  input  logic        mul_overflow,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [32:0] rsp0_data,
  output logic [1:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [32:0] rsp1_data,
  output logic [1:0]  rsp1_flags,
  output logic        busy
`ifdef FMUL_ARB_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_errors
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  elig;
  logic [1:0]  gnt;

  logic [1:0]  st_q        [2];
  logic [1:0]  st_d        [2];
  logic [32:0] rsp_data_q  [2];
  logic [32:0] rsp_data_d  [2];
  logic [1:0]  rsp_flags_q [2];
  logic [1:0]  rsp_flags_d [2];

  logic        prio_q, prio_d;           // port that wins when both are eligible
  logic        issue_vld_q, issue_vld_d;
  logic        issue_id_q, issue_id_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Grants are suppressed during reset so no handshake can be seen on a reset edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = !rst && (st_q[i] == ST_IDLE) && req_valid[i];
    end
    gnt[0] = elig[0] && (!elig[1] || !prio_q);
    gnt[1] = elig[1] && (!elig[0] ||  prio_q);
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    prio_d      = prio_q;
    issue_vld_d = |gnt;
    issue_id_d  = issue_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    if (|gnt) begin
      prio_d     = gnt[0];
      issue_id_d = gnt[1];
      mul_a_d    = gnt[1] ? req1_a : req0_a;
      mul_b_d    = gnt[1] ? req1_b : req0_b;
    end

    for (int i = 0; i < 2; i++) begin
      st_d[i]        = st_q[i];
      rsp_data_d[i]  = rsp_data_q[i];
      rsp_flags_d[i] = rsp_flags_q[i];
      case (st_q[i])
        ST_IDLE: if (gnt[i]) st_d[i] = ST_BUSY;
        ST_BUSY: begin
          if (issue_vld_q && (issue_id_q == 1'(i))) begin
            st_d[i]        = ST_DONE;
            rsp_data_d[i]  = {mul_sign, mul_exp, mul_frac};
            rsp_flags_d[i] = {mul_error, mul_overflow};
          end
        end
        ST_DONE: if (rsp_ready[i]) st_d[i] = ST_IDLE;
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // NOTE: the two response buffers are reset too; their contents are visible on rspN_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]        <= ST_IDLE;
        rsp_data_q[i]  <= '0;
        rsp_flags_q[i] <= '0;
      end
      prio_q      <= RR_INIT;
      issue_vld_q <= 1'b0;
      issue_id_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      st_q        <= st_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      prio_q      <= prio_d;
      issue_vld_q <= issue_vld_d;
      issue_id_q  <= issue_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

`ifdef FMUL_ARB_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_errors_q, stat_errors_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_errors_d = stat_errors_q;
    if ((|gnt) && (stat_issued_q != 16'hFFFF)) stat_issued_d = stat_issued_q + 16'd1;
    if (issue_vld_q && mul_error && (stat_errors_q != 16'hFFFF)) stat_errors_d = stat_errors_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_errors_q <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_errors_q <= stat_errors_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_errors = stat_errors_q;
`endif

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp0_valid = (st_q[0] == ST_DONE);
  assign rsp1_valid = (st_q[1] == ST_DONE);
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp0_flags = rsp_flags_q[0];
  assign rsp1_flags = rsp_flags_q[1];
  assign busy       = (st_q[0] != ST_IDLE) || (st_q[1] != ST_IDLE);

endmodule
